hilo_unit: RTL



---
 rtl/hilo_pkg.sv | 28 ++
 rtl/hilo_div_iter.sv | 63 ++++++
 rtl/hilo_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Purpose  : shared op encodings, FSM states and constants for the HI/LO unit.
// Latency  : n/a (declarations only).
// Backpress: n/a.
// Contents : OP_* encodings, state_t, DIV_ITERS, DIV0_LO, counter width, op decode helpers.
package hilo_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;
  // Wide enough for DIV_ITERS-1 and MUL_LAT-1.
  localparam int          CNT_W     = 5;

  // op[1] selects divide; op[0]=0 selects the signed flavour.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// Purpose  : unsigned restoring divider core, one quotient bit per step, MSB first.
// Latency  : load takes one edge, then WIDTH step edges produce quotient/remainder.
// Backpress: none; the caller sequences load/step.
// Ports    : clk, rst (async, active-high), load, step, dividend, divisor -> quotient, remainder.
module hilo_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // quo_q starts as the dividend; each step shifts a dividend bit out of the
  // top and a quotient bit in at the bottom.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    trial = {rem_q, quo_q[WIDTH-1]};
    // rem < divisor, so trial < 2*divisor: diff's MSB is a clean borrow flag.
    diff  = trial - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_unit.sv
// Purpose  : owns HI/LO; direct writes plus multi-cycle MULT/MULTU/DIV/DIVU.
// Latency  : MUL = MUL_LAT edges, DIV = 33 edges, divide-by-zero = 1 edge (start sample to commit).
// Backpress: busy high while an op is in flight; start and direct writes are dropped then.
// Ports    : clk, rst, start, op, a, b, hi_wr, lo_wr, hi_wdata, lo_wdata -> busy, done, div_by_zero, hi, lo.
// Option   : HILO_FORWARD_EN bypasses accepted direct-write data onto hi/lo in the same cycle.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               div_load, div_step;
  logic [WIDTH-1:0]   quo, rem;
  logic               is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_full;
  logic               idle_wr_ok, hi_acc, lo_acc;

  assign is_signed = op_is_signed(op);
  // -x of the most negative value is 2^(WIDTH-1) read as unsigned, which is the true magnitude.
  assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // Extending to 2*WIDTH makes the truncated unsigned product correct for both signednesses.
  assign a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod_full = a_ext * b_ext;

  // start takes priority over a direct write issued in the same idle cycle.
  assign idle_wr_ok = (state_q == IDLE) && !start;
  assign hi_acc     = idle_wr_ok && hi_wr;
  assign lo_acc     = idle_wr_ok && lo_wr;

  hilo_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      a_q       <= a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op_is_div(op))  state_d = MUL;
          else if (b == '0)    state_d = FIX;
          else                 state_d = DIV;
        end
      end
      MUL:     if (cnt_q == '0) state_d = IDLE;
      DIV:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic.
  always_comb begin
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    a_d       = a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          dbz_d = 1'b0;
          if (op_is_div(op)) begin
            neg_quo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = is_signed && a[WIDTH-1];
            cnt_d     = CNT_W'(DIV_ITERS - 1);
            if (b == '0) dbz_d    = 1'b1;
            else         div_load = 1'b1;
          end else begin
            prod_d = prod_full;
            cnt_d  = CNT_W'(MUL_LAT - 1);
          end
        end
        if (hi_acc) hi_d = hi_wdata;
        if (lo_acc) lo_d = lo_wdata;
      end
      MUL: begin
        if (cnt_q == '0) begin
          hi_d   = prod_q[2*WIDTH-1:WIDTH];
          lo_d   = prod_q[WIDTH-1:0];
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        done_d = 1'b1;
        if (dbz_q) begin
          lo_d = WIDTH'(DIV0_LO);
          hi_d = a_q;
        end else begin
          lo_d = neg_quo_q ? -quo : quo;
          hi_d = neg_rem_q ? -rem : rem;
        end
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

`ifdef HILO_FORWARD_EN
  assign hi = hi_acc ? hi_wdata : hi_q;
  assign lo = lo_acc ? lo_wdata : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule
